// File: rtl/axi4_track_pkg.sv
// Shared definitions for the AXI4 write-burst monitor: error bit indices and
// a priority helper that picks the lowest set error index.
package axi4_track_pkg;

  localparam int ERR_W       = 8;

  localparam int OVF         = 0;
  localparam int WLAST_EARLY = 1;
  localparam int WLAST_MISS  = 2;
  localparam int B_EARLY     = 3;
  localparam int BID         = 4;
  localparam int BRESP       = 5;
  localparam int TIMEOUT     = 6;
  localparam int W_NO_AW     = 7;

  function automatic logic [2:0] first_err_idx(input logic [ERR_W-1:0] errs);
    first_err_idx = 3'd0;
    for (int i = ERR_W - 1; i >= 0; i--) begin
      if (errs[i]) first_err_idx = 3'(i);
    end
  endfunction

endpackage

// File: rtl/axi4_track_buf.sv
// Tracking buffer for outstanding write bursts: one write port, two
// combinational read ports (W stage reads the length, B stage reads the ID).
module axi4_track_buf
  import axi4_track_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int IDSIZE = 4,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [IDSIZE-1:0] wr_id,
  input  logic [7:0]        wr_len,
  input  logic [AW-1:0]     w_addr,
  output logic [7:0]        w_len,
  input  logic [AW-1:0]     b_addr,
  output logic [IDSIZE-1:0] b_id
);

  logic [IDSIZE+7:0] mem [DEPTH];

  // NOTE: the array has no reset; an entry is only read after it has been
  // written, and the pointers that guard it are reset in the parent.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {wr_id, wr_len};
  end

  assign w_len = mem[w_addr][7:0];
  assign b_id  = mem[b_addr][IDSIZE+7:8];

endmodule

// File: rtl/axi4_wr_burst_monitor.sv
// Passive AXI4 write-channel protocol monitor: tracks AW/W/B ordering per
// burst and latches sticky protocol errors with first-error capture.
module axi4_wr_burst_monitor
  import axi4_track_pkg::*;
#(
  parameter int IDSIZE    = 4,
  parameter int DEPTH     = 16,
  parameter int MAX_CYCLE = 1000,
  parameter bit CHK_RESP  = 1'b1,
  parameter bit SIM_STOP  = 1'b0
) (
  input  logic                     axi_aclk,
  input  logic                     axi_aresetn,
  input  logic [IDSIZE-1:0]        axi_awid,
  input  logic [7:0]               axi_awlen,
  input  logic                     axi_awvalid,
  input  logic                     axi_awready,
  input  logic                     axi_wlast,
  input  logic                     axi_wvalid,
  input  logic                     axi_wready,
  input  logic [IDSIZE-1:0]        axi_bid,
  input  logic [1:0]               axi_bresp,
  input  logic                     axi_bvalid,
  input  logic                     axi_bready,
  input  logic                     err_clr,
  output logic [ERR_W-1:0]         err_flags,
  output logic [2:0]               err_first,
  output logic                     err_valid,
  output logic                     err_irq,
  output logic [$clog2(DEPTH):0]   outstanding
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int IW = $clog2(MAX_CYCLE + 1) + 1;

  logic [PW-1:0]     wr_ptr, w_ptr, b_ptr;
  logic [PW-1:0]     wr_ptr_nxt, b_ptr_nxt, count;
  logic [7:0]        beat_cnt;
  logic [IW-1:0]     idle_cnt;
  logic [7:0]        buf_w_len, cur_len;
  logic [IDSIZE-1:0] buf_b_id;
  logic              aw_hs, w_hs, b_hs;
  logic              full, b_early, b_pop, ovf, push;
  logic              w_empty, w_track, last_beat, w_retire;
  logic [ERR_W-1:0]  new_err;

  assign aw_hs   = axi_awvalid & axi_awready;
  assign w_hs    = axi_wvalid  & axi_wready;
  assign b_hs    = axi_bvalid  & axi_bready;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count   = wr_ptr - b_ptr;
  assign full    = (count == PW'(DEPTH));
  assign b_early = (b_ptr == w_ptr);
  assign b_pop   = b_hs & ~b_early;
  assign ovf     = aw_hs & full & ~b_pop;
  assign push    = aw_hs & ~ovf;

  // With no pending entry, a same-cycle AW supplies the length directly.
  assign w_empty   = (w_ptr == wr_ptr);
  assign w_track   = w_hs & (~w_empty | push);
  assign cur_len   = w_empty ? axi_awlen : buf_w_len;
  assign last_beat = (beat_cnt == cur_len);
  assign w_retire  = w_track & (axi_wlast | last_beat);

  assign wr_ptr_nxt = wr_ptr + PW'(push);
  assign b_ptr_nxt  = b_ptr + PW'(b_pop);

  axi4_track_buf #(
    .DEPTH  (DEPTH),
    .IDSIZE (IDSIZE)
  ) u_buf (
    .clk     (axi_aclk),
    .wr_en   (push),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_id   (axi_awid),
    .wr_len  (axi_awlen),
    .w_addr  (w_ptr[AW-1:0]),
    .w_len   (buf_w_len),
    .b_addr  (b_ptr[AW-1:0]),
    .b_id    (buf_b_id)
  );

  // NOTE: every signal driven here gets a default first so no latch can form.
  always_comb begin
    new_err              = '0;
    new_err[OVF]         = ovf;
    new_err[WLAST_EARLY] = w_track & axi_wlast & ~last_beat;
    new_err[WLAST_MISS]  = w_track & last_beat & ~axi_wlast;
    new_err[B_EARLY]     = b_hs & b_early;
    new_err[BID]         = b_pop & (axi_bid != buf_b_id);
    new_err[BRESP]       = CHK_RESP & b_hs & (axi_bresp != 2'b00);
    new_err[TIMEOUT]     = (idle_cnt == IW'(MAX_CYCLE));
    new_err[W_NO_AW]     = w_hs & w_empty & ~aw_hs;
  end

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples the pre-edge values of its peers.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wr_ptr      <= '0;
      w_ptr       <= '0;
      b_ptr       <= '0;
      beat_cnt    <= '0;
      idle_cnt    <= '0;
      outstanding <= '0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      b_ptr       <= b_ptr_nxt;
      outstanding <= wr_ptr_nxt - b_ptr_nxt;

      if (w_retire) begin
        w_ptr    <= w_ptr + PW'(1);
        beat_cnt <= '0;
      end else if (w_track) begin
        beat_cnt <= beat_cnt + 8'd1;
      end

      // err_clr also restarts the idle window so a cleared timeout is not
      // re-flagged on the very next cycle.
      if (err_clr || aw_hs || w_hs || b_hs || count == '0)
        idle_cnt <= '0;
      else if (idle_cnt != IW'(MAX_CYCLE))
        idle_cnt <= idle_cnt + IW'(1);
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      err_flags <= '0;
      err_first <= '0;
      err_valid <= 1'b0;
      err_irq   <= 1'b0;
    end else if (err_clr) begin
      err_flags <= '0;
      err_first <= '0;
      err_valid <= 1'b0;
      err_irq   <= 1'b0;
    end else begin
      err_flags <= err_flags | new_err;
      err_irq   <= 1'b0;
      if (!err_valid && (|new_err)) begin
        err_first <= first_err_idx(new_err);
        err_valid <= 1'b1;
        err_irq   <= 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  if (SIM_STOP) begin : g_sim_stop
    realtime stop_at;
    logic    armed;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
        armed   <= 1'b0;
        stop_at <= 0.0;
      end else if (!armed && err_valid) begin
        armed   <= 1'b1;
        stop_at <= $realtime + 10us;
      end else if (armed && $realtime >= stop_at) begin
        $finish;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi4_wr_burst_monitor.sv
// Directed scoreboard bench for axi4_wr_burst_monitor (DEPTH=4, MAX_CYCLE=20).
module tb_axi4_wr_burst_monitor;

  localparam int IDSIZE    = 4;
  localparam int DEPTH     = 4;
  localparam int MAX_CYCLE = 20;

  logic              axi_aclk = 1'b0;
  logic              axi_aresetn;
  logic [IDSIZE-1:0] axi_awid, axi_bid;
  logic [7:0]        axi_awlen;
  logic              axi_awvalid, axi_awready;
  logic              axi_wlast, axi_wvalid, axi_wready;
  logic [1:0]        axi_bresp;
  logic              axi_bvalid, axi_bready;
  logic              err_clr;
  logic [7:0]        err_flags;
  logic [2:0]        err_first;
  logic              err_valid, err_irq;
  logic [2:0]        outstanding;

  int n_vec  = 0;
  int n_miss = 0;
  int irq_cnt = 0;

  typedef struct {
    string      tag;
    logic [7:0] flags;
    logic [2:0] first;
    logic       valid;
    logic [2:0] outst;
  } exp_t;

  exp_t sb[$];

  axi4_wr_burst_monitor #(
    .IDSIZE    (IDSIZE),
    .DEPTH     (DEPTH),
    .MAX_CYCLE (MAX_CYCLE),
    .CHK_RESP  (1'b1),
    .SIM_STOP  (1'b0)
  ) dut (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .axi_awid    (axi_awid),
    .axi_awlen   (axi_awlen),
    .axi_awvalid (axi_awvalid),
    .axi_awready (axi_awready),
    .axi_wlast   (axi_wlast),
    .axi_wvalid  (axi_wvalid),
    .axi_wready  (axi_wready),
    .axi_bid     (axi_bid),
    .axi_bresp   (axi_bresp),
    .axi_bvalid  (axi_bvalid),
    .axi_bready  (axi_bready),
    .err_clr     (err_clr),
    .err_flags   (err_flags),
    .err_first   (err_first),
    .err_valid   (err_valid),
    .err_irq     (err_irq),
    .outstanding (outstanding)
  );

  always #5 axi_aclk = ~axi_aclk;

  always @(negedge axi_aclk) if (err_irq === 1'b1) irq_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic [7:0] flags, input logic [2:0] first,
                              input logic valid, input logic [2:0] outst);
    exp_t e;
    e.tag = tag; e.flags = flags; e.first = first; e.valid = valid; e.outst = outst;
    sb.push_back(e);
  endtask

  task automatic score();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, ".flags"}, 32'(err_flags),   32'(e.flags));
      check({e.tag, ".first"}, 32'(err_first),   32'(e.first));
      check({e.tag, ".valid"}, 32'(err_valid),   32'(e.valid));
      check({e.tag, ".outst"}, 32'(outstanding), 32'(e.outst));
    end
  endtask

  task automatic tick();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic idle_inputs();
    axi_awid = '0; axi_awlen = '0; axi_awvalid = 0; axi_awready = 0;
    axi_wlast = 0; axi_wvalid = 0; axi_wready = 0;
    axi_bid = '0; axi_bresp = '0; axi_bvalid = 0; axi_bready = 0;
    err_clr = 0;
  endtask

  task automatic apply_reset(input string tag);
    idle_inputs();
    axi_aresetn = 1'b0;
    repeat (3) tick();
    expect_state({tag, ".rst"}, 8'h00, 3'd0, 1'b0, 3'd0);
    score();
    check({tag, ".rst.irq"}, 32'(err_irq), 32'd0);
    axi_aresetn = 1'b1;
    tick();
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [7:0] len);
    axi_awid = id; axi_awlen = len; axi_awvalid = 1; axi_awready = 1;
    tick();
    axi_awvalid = 0; axi_awready = 0;
  endtask

  task automatic do_w(input logic last);
    axi_wlast = last; axi_wvalid = 1; axi_wready = 1;
    tick();
    axi_wvalid = 0; axi_wready = 0; axi_wlast = 0;
  endtask

  task automatic do_aw_w(input logic [3:0] id, input logic [7:0] len, input logic last);
    axi_awid = id; axi_awlen = len; axi_awvalid = 1; axi_awready = 1;
    axi_wlast = last; axi_wvalid = 1; axi_wready = 1;
    tick();
    axi_awvalid = 0; axi_awready = 0; axi_wvalid = 0; axi_wready = 0; axi_wlast = 0;
  endtask

  task automatic w_burst(input int len);
    for (int i = 0; i <= len; i++) do_w(i == len);
  endtask

  task automatic do_b(input logic [3:0] id, input logic [1:0] resp);
    axi_bid = id; axi_bresp = resp; axi_bvalid = 1; axi_bready = 1;
    tick();
    axi_bvalid = 0; axi_bready = 0; axi_bresp = '0;
  endtask

  initial begin
    int base;
    idle_inputs();
    axi_aresetn = 1'b0;

    // Clean traffic: three bursts then a same-cycle AW+W bypass burst.
    apply_reset("clean");
    do_aw(4'd1, 8'd0);
    do_aw(4'd2, 8'd3);
    do_aw(4'd3, 8'd15);
    expect_state("clean.aw3", 8'h00, 3'd0, 1'b0, 3'd3);
    score();
    w_burst(0);
    w_burst(3);
    w_burst(15);
    do_b(4'd1, 2'b00);
    do_b(4'd2, 2'b00);
    do_b(4'd3, 2'b00);
    expect_state("clean.done", 8'h00, 3'd0, 1'b0, 3'd0);
    score();
    do_aw_w(4'd4, 8'd1, 1'b0);
    do_w(1'b1);
    do_b(4'd4, 2'b00);
    expect_state("bypass", 8'h00, 3'd0, 1'b0, 3'd0);
    score();

    // Overflow: fifth AW with DEPTH=4 outstanding and no B.
    apply_reset("ovf");
    base = irq_cnt;
    for (int i = 0; i < 5; i++) do_aw(4'(i), 8'd0);
    expect_state("ovf", 8'h01, 3'd0, 1'b1, 3'd4);
    score();
    repeat (2) tick();
    check("ovf.irq_pulses", 32'(irq_cnt - base), 32'd1);
    check("ovf.irq_low", 32'(err_irq), 32'd0);

    // Early WLAST, then a correct burst adds nothing.
    apply_reset("wlast");
    base = irq_cnt;
    do_aw(4'd1, 8'd3);
    do_w(1'b0);
    do_w(1'b1);
    do_b(4'd1, 2'b00);
    expect_state("wlast.early", 8'h02, 3'd1, 1'b1, 3'd0);
    score();
    do_aw(4'd2, 8'd1);
    w_burst(1);
    do_b(4'd2, 2'b00);
    expect_state("wlast.resync", 8'h02, 3'd1, 1'b1, 3'd0);
    score();
    repeat (2) tick();
    check("wlast.irq_pulses", 32'(irq_cnt - base), 32'd1);

    // BID mismatch, then a SLVERR response keeps err_first at BID.
    apply_reset("bresp");
    do_aw(4'd5, 8'd0);
    w_burst(0);
    do_b(4'd6, 2'b00);
    expect_state("bid", 8'h10, 3'd4, 1'b1, 3'd0);
    score();
    do_aw(4'd3, 8'd0);
    w_burst(0);
    do_b(4'd3, 2'b10);
    expect_state("bresp", 8'h30, 3'd4, 1'b1, 3'd0);
    score();

    // Timeout exactly 21 cycles after the AW, then err_clr.
    apply_reset("tmo");
    do_aw(4'd7, 8'd0);
    repeat (20) tick();
    expect_state("tmo.before", 8'h00, 3'd0, 1'b0, 3'd1);
    score();
    tick();
    expect_state("tmo.hit", 8'h40, 3'd6, 1'b1, 3'd1);
    score();
    check("tmo.irq_hi", 32'(err_irq), 32'd1);
    tick();
    check("tmo.irq_lo", 32'(err_irq), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    expect_state("tmo.clr", 8'h00, 3'd0, 1'b0, 3'd1);
    score();
    check("tmo.clr.irq", 32'(err_irq), 32'd0);
    do_b(4'd7, 2'b00);
    expect_state("b_early", 8'h08, 3'd3, 1'b1, 3'd1);
    score();
    do_w(1'b1);
    do_w(1'b1);
    expect_state("w_no_aw", 8'h88, 3'd3, 1'b1, 3'd1);
    score();

    // Reset mid-burst discards the tracked entry.
    apply_reset("midrst");
    do_aw(4'd1, 8'd3);
    do_w(1'b0);
    do_w(1'b0);
    axi_aresetn = 1'b0;
    #2;
    expect_state("midrst.in", 8'h00, 3'd0, 1'b0, 3'd0);
    score();
    repeat (2) tick();
    axi_aresetn = 1'b1;
    tick();
    do_aw(4'd2, 8'd1);
    w_burst(1);
    do_b(4'd2, 2'b00);
    expect_state("midrst.clean", 8'h00, 3'd0, 1'b0, 3'd0);
    score();
    repeat (MAX_CYCLE + 5) tick();
    expect_state("midrst.quiet", 8'h00, 3'd0, 1'b0, 3'd0);
    score();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/axi4_wr_burst_monitor.md
AXI4_WR_BURST_MONITOR -- requirements
Module: axi4_wr_burst_monitor

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- IDSIZE, 4, AXI ID width.
- DEPTH, 16, maximum outstanding write bursts tracked (power of 2, 2..256).
- MAX_CYCLE, 1000, idle cycles allowed with bursts outstanding.
- CHK_RESP, 1, flag a BRESP other than OKAY as an error.
- SIM_STOP, 0, when 1, simulation stops 10us after the first error (synthesis-excluded).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- axi_aclk, in, 1, the single clock.
- axi_aresetn, in, 1, asynchronous active-low reset.
- axi_awid, in, IDSIZE, AW channel ID.
- axi_awlen, in, 8, AW channel burst length.
- axi_awvalid / axi_awready, in, 1 each, AW handshake.
- axi_wlast, in, 1, W channel last beat.
- axi_wvalid / axi_wready, in, 1 each, W handshake.
- axi_bid, in, IDSIZE, B channel ID.
- axi_bresp, in, 2, B channel response.
- axi_bvalid / axi_bready, in, 1 each, B handshake.
- err_clr, in, 1, synchronous clear of the error state.
- err_flags, out, 8, sticky error vector.
- err_first, out, 3, index of the first error.
- err_valid, out, 1, err_first holds a valid index.
- err_irq, out, 1, one-cycle pulse on the first error.
- outstanding, out, $clog2(DEPTH)+1, number of bursts accepted on AW and not yet responded on B.

Function
REQ-003 The block SHALL be passive: it never drives any AXI signal.
REQ-004 An AW handshake SHALL push {awid, awlen} into the tracking buffer at wr_ptr.
REQ-005 The W stage SHALL check the entry at w_ptr:
- A beat counter counts accepted W beats for that entry.
- The burst completes on beat awlen+1, and w_ptr then advances.
REQ-006 A B handshake SHALL pop the entry at b_ptr, and outstanding SHALL decrement.
REQ-007 outstanding SHALL equal wr_ptr minus b_ptr, registered with 1-cycle latency after the handshake.
REQ-008 Error bit indices SHALL be:
- 0 OVF: AW accepted while outstanding==DEPTH and no B pop occurs in the same cycle.
- 1 WLAST_EARLY: wlast on a beat before awlen+1.
- 2 WLAST_MISS: beat awlen+1 arrives without wlast.
- 3 B_EARLY: B handshake while b_ptr==w_ptr, i.e. the burst's W phase is incomplete or nothing is outstanding.
- 4 BID: bid differs from the stored awid at b_ptr.
- 5 BRESP: bresp!=0 and CHK_RESP==1.
- 6 TIMEOUT: the idle counter reaches MAX_CYCLE.
- 7 W_NO_AW: W beat accepted while w_ptr==wr_ptr and no AW handshake occurs in the same cycle.
REQ-009 Same-cycle AW and first W beat SHALL bypass: the W beat is checked against the incoming awlen.
REQ-010 On WLAST_EARLY the entry SHALL retire at that beat. On WLAST_MISS the entry SHALL retire at beat awlen+1. Either way tracking resynchronises.
REQ-011 On OVF the push SHALL be dropped and the pointers left unchanged.
REQ-012 Idle counter behaviour:
- Width is $clog2(MAX_CYCLE+1)+1.
- It is cleared on any AW, W or B handshake, or when outstanding==0.
- It otherwise increments and saturates at MAX_CYCLE.
REQ-013 Error latching:
- Each err_flags bit is sticky until err_clr; err_clr wins over a same-cycle new error.
- err_first/err_valid capture the lowest set index among errors in the first erroring cycle.
- err_irq pulses in that same capture cycle only.
REQ-014 All outputs SHALL be registered. Errors SHALL appear 1 cycle after the offending handshake.
REQ-015 When SIM_STOP==1, simulation SHALL call $finish 10us after err_valid rises.

Reset
REQ-016 While axi_aresetn is low, the following SHALL be 0: all pointers, beat counter, idle counter, err_flags, err_first, err_valid, err_irq and outstanding.
REQ-017 Reset mid-burst SHALL discard all tracked entries, with no error raised on release.

Structure
REQ-018 Package axi4_track_pkg SHALL hold the error-index localparams (OVF..W_NO_AW) and ERR_W=8.
REQ-019 Sub-module axi4_track_buf SHALL hold the DEPTH x (IDSIZE+8) register array:
- One write port (wr_ptr).
- Two asynchronous read ports (w_ptr, b_ptr).

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- 3 bursts (awlen 0, 3, 15), correct wlast, in-order B OKAY -> err_flags==0, outstanding returns to 0.
- DEPTH=4, 5 AWs with no B -> err_flags[0]=1, err_first=0, err_irq one pulse, outstanding==4.
- awlen=3, wlast on beat 2 -> err_flags[1]=1; the next correct burst raises no further error.
- AW id=5, B with bid=6 -> err_flags[4]=1. With CHK_RESP=1, bresp=2 also sets bit 5 and err_first=4.
- MAX_CYCLE=20, one AW then idle -> err_flags[6]=1 at exactly 21 cycles after the AW; err_clr then clears all outputs.
- Reset asserted mid-burst, then a clean burst -> no errors.
